// File: rtl/lcd_write_arbiter_if.sv
// Requester-side and LCD-driver-side handshake bundle for lcd_write_arbiter.
// The slave modport is the arbiter; the master modport is its environment.
interface lcd_write_arbiter_if #(
  parameter int N_REQ = 3
);
  logic [N_REQ-1:0]   req;
  logic [7*N_REQ-1:0] addr;
  logic [N_REQ-1:0]   wr_valid;
  logic [8*N_REQ-1:0] wr_data;
  logic [N_REQ-1:0]   wr_last;
  logic [N_REQ-1:0]   wr_ready;
  logic [N_REQ-1:0]   grant;
  logic               lcd_valid;
  logic               lcd_rs;
  logic [7:0]         lcd_data;
  logic               lcd_ready;
  logic               timeout_err;

  modport master (
    output req, addr, wr_valid, wr_data, wr_last, lcd_ready,
    input  wr_ready, grant, lcd_valid, lcd_rs, lcd_data, timeout_err
  );

  modport slave (
    input  req, addr, wr_valid, wr_data, wr_last, lcd_ready,
    output wr_ready, grant, lcd_valid, lcd_rs, lcd_data, timeout_err
  );
endinterface

// File: rtl/lcd_write_arbiter.sv
// Round-robin arbiter sharing one HD44780 write path between N_REQ producers.
// Each burst is prefixed with a Set-DDRAM-Address command beat.
module lcd_write_arbiter #(
  parameter int N_REQ   = 3,
  parameter int TIMEOUT = 1000,
  parameter int MAX_LEN = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  lcd_write_arbiter_if.slave bus
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t           state_r, state_nxt;
  logic [PW-1:0]    ptr_r, own_r, pick_s;
  logic [N_REQ-1:0] grant_r;
  logic             lcd_valid_r, lcd_rs_r, timeout_err_r;
  logic [7:0]       lcd_data_r;
  logic [CW-1:0]    char_cnt_r;
  logic [15:0]      stall_cnt_r;

  logic             own_valid_s, own_last_s;
  logic [7:0]       own_data_s;
  logic [6:0]       pick_addr_s;
  logic             out_free_s, xfer_s, load_cmd_s, end_burst_s, timeout_hit_s;

  // Select the owner's write channel and the candidate's start address.
  always_comb begin
    own_valid_s = 1'b0;
    own_last_s  = 1'b0;
    own_data_s  = 8'h00;
    pick_addr_s = 7'h00;
    for (int i = 0; i < N_REQ; i++) begin
      own_valid_s = (own_r == PW'(i)) ? bus.wr_valid[i] : own_valid_s;
      own_last_s  = (own_r == PW'(i)) ? bus.wr_last[i] : own_last_s;
      own_data_s  = (own_r == PW'(i)) ? bus.wr_data[8*i +: 8] : own_data_s;
      pick_addr_s = (pick_s == PW'(i)) ? bus.addr[7*i +: 7] : pick_addr_s;
    end
  end

  // Round-robin pick: scan downward in offset so the nearest request above the pointer wins.
  always_comb begin
    int j;
    pick_s = {PW{1'b0}};
    j      = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      j      = int'(ptr_r) + i;
      j      = (j >= N_REQ) ? (j - N_REQ) : j;
      pick_s = bus.req[j] ? PW'(j) : pick_s;
    end
  end

  assign out_free_s = !lcd_valid_r || bus.lcd_ready;
  assign xfer_s     = (state_r == STREAM) && own_valid_s && out_free_s;

  // Next-state and burst control strobes.
  always_comb begin
    state_nxt     = state_r;
    load_cmd_s    = 1'b0;
    end_burst_s   = 1'b0;
    timeout_hit_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (|bus.req) begin
          state_nxt  = STREAM;
          load_cmd_s = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      STREAM: begin
        if (xfer_s) begin
          if (own_last_s || (char_cnt_r == CW'(MAX_LEN - 1))) begin
            state_nxt = DRAIN;
          end else begin
            state_nxt = STREAM;
          end
        end else if (!own_valid_s && (stall_cnt_r == 16'(TIMEOUT - 1))) begin
          state_nxt     = DRAIN;
          timeout_hit_s = 1'b1;
        end else begin
          state_nxt = STREAM;
        end
      end
      DRAIN: begin
        if (out_free_s) begin
          state_nxt   = IDLE;
          end_burst_s = 1'b1;
        end else begin
          state_nxt = DRAIN;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Output beat register, ownership, pointer and counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_r       <= {N_REQ{1'b0}};
      own_r         <= {PW{1'b0}};
      ptr_r         <= {PW{1'b0}};
      lcd_valid_r   <= 1'b0;
      lcd_rs_r      <= 1'b0;
      lcd_data_r    <= 8'h00;
      char_cnt_r    <= {CW{1'b0}};
      stall_cnt_r   <= 16'h0000;
      timeout_err_r <= 1'b0;
    end else begin
      timeout_err_r <= timeout_hit_s;
      if (load_cmd_s) begin
        grant_r     <= {{(N_REQ-1){1'b0}}, 1'b1} << pick_s;
        own_r       <= pick_s;
        lcd_valid_r <= 1'b1;
        lcd_rs_r    <= 1'b0;
        lcd_data_r  <= 8'h80 | {1'b0, pick_addr_s};
        char_cnt_r  <= {CW{1'b0}};
        stall_cnt_r <= 16'h0000;
      end else if (xfer_s) begin
        lcd_valid_r <= 1'b1;
        lcd_rs_r    <= 1'b1;
        lcd_data_r  <= own_data_s;
        char_cnt_r  <= char_cnt_r + CW'(1);
        stall_cnt_r <= 16'h0000;
      end else begin
        if (bus.lcd_ready) begin
          lcd_valid_r <= 1'b0;
        end
        // Back-pressure with data waiting is not a stall; only an idle owner is.
        if ((state_r == STREAM) && !own_valid_s) begin
          stall_cnt_r <= stall_cnt_r + 16'd1;
        end
      end
      if (end_burst_s) begin
        grant_r <= {N_REQ{1'b0}};
        ptr_r   <= (own_r == PW'(N_REQ - 1)) ? {PW{1'b0}} : (own_r + PW'(1));
      end
    end
  end

  assign bus.wr_ready    = (state_r == STREAM) ? (grant_r & {N_REQ{out_free_s}}) : {N_REQ{1'b0}};
  assign bus.grant       = grant_r;
  assign bus.lcd_valid   = lcd_valid_r;
  assign bus.lcd_rs      = lcd_rs_r;
  assign bus.lcd_data    = lcd_data_r;
  assign bus.timeout_err = timeout_err_r;
endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Directed bench for lcd_write_arbiter: reset, contention, single burst,
// back-pressure, timeout, length cap and asynchronous reset mid-burst.
module tb_lcd_write_arbiter;
  localparam int N = 3;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  lcd_write_arbiter_if #(.N_REQ(N)) bus ();

  lcd_write_arbiter #(.N_REQ(N), .TIMEOUT(8), .MAX_LEN(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] cap_data[$];
  logic       cap_rs[$];
  int         sent, to_seen, to_edge, last_xfer, unstable;
  bit         done;

  logic [2:0] cont_grant [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
  logic [7:0] cont_data  [4] = '{8'h41, 8'h42, 8'h43, 8'h41};
  logic [7:0] bp_data    [4] = '{8'h85, 8'h58, 8'h59, 8'h5A};
  logic       bp_rs      [4] = '{1'b0, 1'b1, 1'b1, 1'b1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_src(input int r, input int n, input logic [7:0] base, input bit use_last);
    bus.wr_valid[r]       = (sent < n);
    bus.wr_data[8*r +: 8] = base + 8'(sent);
    bus.wr_last[r]        = use_last && (sent == n - 1);
  endtask

  // Requester r streams n characters (base, base+1, ...) until its grant ends.
  task automatic stream(input int r, input int n, input logic [7:0] base, input bit use_last,
                        input bit toggle, input logic [6:0] a, input int max_cyc);
    logic       held_v = 1'b0;
    logic [7:0] held_d = 8'h00;
    logic       held_rs = 1'b0;
    bit         granted = 1'b0;
    bit         fire;
    cap_data.delete();
    cap_rs.delete();
    sent = 0; to_seen = 0; to_edge = -1; last_xfer = -1; unstable = 0; done = 1'b0;
    bus.addr[7*r +: 7] = a;
    bus.req[r] = 1'b1;
    drive_src(r, n, base, use_last);
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      bus.lcd_ready = toggle ? ((cyc % 2) == 1) : 1'b1;
      #1;
      if (held_v && ((bus.lcd_data !== held_d) || (bus.lcd_rs !== held_rs))) unstable++;
      if (bus.lcd_valid && bus.lcd_ready) begin
        cap_data.push_back(bus.lcd_data);
        cap_rs.push_back(bus.lcd_rs);
      end
      held_v  = bus.lcd_valid && !bus.lcd_ready;
      held_d  = bus.lcd_data;
      held_rs = bus.lcd_rs;
      fire    = bus.wr_valid[r] && bus.wr_ready[r];
      if (bus.timeout_err) begin
        to_seen++;
        to_edge = cyc;
      end
      if (bus.grant != 3'b000) granted = 1'b1;
      else if (granted) done = 1'b1;
      if (done) break;
      @(posedge clk);
      #1;
      if (fire) begin
        sent++;
        last_xfer = cyc + 1;
      end
      if (granted) bus.req[r] = 1'b0;
      drive_src(r, n, base, use_last);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n       = 1'b1;
    bus.req       = 3'b000;
    bus.addr      = 21'h0;
    bus.wr_valid  = 3'b000;
    bus.wr_data   = 24'h0;
    bus.wr_last   = 3'b000;
    bus.lcd_ready = 1'b0;
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", bus.grant, 3'b000);
    chk("rst_wr_ready", bus.wr_ready, 3'b000);
    chk("rst_lcd_valid", bus.lcd_valid, 1'b0);
    chk("rst_lcd_data", {bus.lcd_rs, bus.lcd_data}, 9'h000);
    chk("rst_timeout", bus.timeout_err, 1'b0);
    #3 reset_n = 1'b1;
    tick();

    // Contention: all three request 1-char bursts; pointer starts at 0.
    bus.lcd_ready = 1'b1;
    bus.req       = 3'b111;
    bus.wr_valid  = 3'b111;
    bus.wr_last   = 3'b111;
    bus.wr_data   = {8'h43, 8'h42, 8'h41};
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("cont_grant", bus.grant, cont_grant[k]);
      chk("cont_cmd", {bus.lcd_rs, bus.lcd_data}, 9'h080);
      tick();
      chk("cont_char", {bus.lcd_rs, bus.lcd_data}, {1'b1, cont_data[k]});
      if (k == 3) bus.req = 3'b000;
      tick();
      chk("cont_gap_grant", bus.grant, 3'b000);
      chk("cont_gap_valid", bus.lcd_valid, 1'b0);
    end
    bus.wr_valid = 3'b000;
    bus.wr_last  = 3'b000;

    // Single burst "P1:" from requester 1 at address 0x40.
    bus.req           = 3'b010;
    bus.addr[13:7]    = 7'h40;
    bus.wr_valid[1]   = 1'b1;
    bus.wr_data[15:8] = 8'h50;
    tick();
    chk("sb_grant0", bus.grant, 3'b010);
    chk("sb_cmd", {bus.lcd_valid, bus.lcd_rs, bus.lcd_data}, 10'h2C0);
    chk("sb_wr_ready0", bus.wr_ready, 3'b010);
    bus.req = 3'b000;
    tick();
    chk("sb_char_p", {bus.lcd_rs, bus.lcd_data}, 9'h150);
    chk("sb_grant1", bus.grant, 3'b010);
    bus.wr_data[15:8] = 8'h31;
    tick();
    chk("sb_char_1", {bus.lcd_rs, bus.lcd_data}, 9'h131);
    bus.wr_data[15:8] = 8'h3A;
    bus.wr_last[1]    = 1'b1;
    tick();
    chk("sb_char_colon", {bus.lcd_rs, bus.lcd_data}, 9'h13A);
    chk("sb_grant3", bus.grant, 3'b010);
    chk("sb_drain_ready", bus.wr_ready, 3'b000);
    bus.wr_valid[1] = 1'b0;
    bus.wr_last[1]  = 1'b0;
    tick();
    chk("sb_end_grant", bus.grant, 3'b000);
    chk("sb_end_valid", bus.lcd_valid, 1'b0);

    // Back-pressure: requester 0 wins after the pointer wraps from 2.
    stream(0, 3, 8'h58, 1'b1, 1'b1, 7'h05, 40);
    chk("bp_done", done, 1'b1);
    chk("bp_beats", cap_data.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("bp_data", cap_data[i], bp_data[i]);
      chk("bp_rs", cap_rs[i], bp_rs[i]);
    end
    chk("bp_stable", unstable, 0);
    chk("bp_no_timeout", to_seen, 0);

    // Timeout: requester 1 sends 2 chars then goes quiet; requester 2 waits.
    bus.req[2] = 1'b1;
    stream(1, 2, 8'h54, 1'b0, 1'b0, 7'h10, 40);
    chk("to_done", done, 1'b1);
    chk("to_pulses", to_seen, 1);
    chk("to_delay", to_edge - last_xfer, 8);
    chk("to_sent", sent, 2);
    chk("to_beats", cap_data.size(), 3);
    chk("to_cmd", cap_data[0], 8'h90);
    tick();
    chk("to_next_grant", bus.grant, 3'b100);
    bus.req[2]         = 1'b0;
    bus.wr_valid[2]    = 1'b1;
    bus.wr_last[2]     = 1'b1;
    bus.wr_data[23:16] = 8'h51;
    tick();
    tick();
    chk("to_next_end", bus.grant, 3'b000);
    bus.wr_valid[2] = 1'b0;
    bus.wr_last[2]  = 1'b0;

    // Length cap: 20 characters offered without wr_last.
    stream(0, 20, 8'h61, 1'b0, 1'b0, 7'h00, 60);
    chk("cap_done", done, 1'b1);
    chk("cap_sent", sent, 16);
    chk("cap_beats", cap_data.size(), 17);
    chk("cap_cmd", {cap_rs[0], cap_data[0]}, 9'h080);
    chk("cap_last", {cap_rs[16], cap_data[16]}, 9'h170);
    chk("cap_ready_off", bus.wr_ready, 3'b000);
    bus.wr_valid[0] = 1'b0;

    // Asynchronous reset while a command beat is pending.
    bus.req            = 3'b100;
    bus.addr[20:14]    = 7'h22;
    bus.lcd_ready      = 1'b0;
    tick();
    chk("rmb_grant", bus.grant, 3'b100);
    chk("rmb_cmd", {bus.lcd_valid, bus.lcd_data}, 9'h1A2);
    bus.req[2]      = 1'b0;
    bus.wr_valid[2] = 1'b1;
    bus.lcd_ready   = 1'b1;
    #1;
    chk("rmb_ready_pre", bus.wr_ready, 3'b100);
    #1 reset_n = 1'b0;
    #1;
    chk("rmb_valid", bus.lcd_valid, 1'b0);
    chk("rmb_grant_drop", bus.grant, 3'b000);
    chk("rmb_ready_drop", bus.wr_ready, 3'b000);
    bus.wr_valid = 3'b000;
    #3 reset_n = 1'b1;
    tick();
    bus.req      = 3'b111;
    bus.wr_valid = 3'b111;
    bus.wr_last  = 3'b111;
    tick();
    chk("rmb_ptr_restart", bus.grant, 3'b001);
    bus.req = 3'b000;
    tick();
    tick();
    chk("rmb_final_idle", bus.grant, 3'b000);
    bus.wr_valid = 3'b000;
    bus.wr_last  = 3'b000;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lcd_write_arbiter.md
# lcd_write_arbiter

Shares the single HD44780 character-LCD write path between several display producers (game-state banner, score panel, dice/round readout). Each producer requests a burst, gets a round-robin grant, and streams characters. The arbiter prefixes each burst with a Set-DDRAM-Address command and forwards one registered command/data beat at a time to the downstream LCD timing driver over a valid/ready handshake.

## Interface
- N_REQ, 3, number of requesters (2..8)
- TIMEOUT, 1000, idle-stall cycles tolerated from a granted requester before the burst is aborted (1..65535)
- MAX_LEN, 16, maximum characters per burst (one LCD line)

- clk  in  1  system clock (50 MHz)
- reset_n  in  1  asynchronous active-low reset
- req  in  N_REQ  burst request, one bit per requester
- addr  in  7*N_REQ  start DDRAM address per requester, slice i = bits [7i+6:7i]
- wr_valid  in  N_REQ  character valid per requester
- wr_data  in  8*N_REQ  character per requester, slice i = bits [8i+7:8i]
- wr_last  in  N_REQ  marks final character of the burst
- wr_ready  out  N_REQ  character accepted this cycle (granted requester only)
- grant  out  N_REQ  one-hot current owner, 0 when idle
- lcd_valid  out  1  output beat valid
- lcd_rs  out  1  0 = command, 1 = character data
- lcd_data  out  8  beat payload
- lcd_ready  in  1  downstream driver accepts beat
- timeout_err  out  1  one-cycle pulse on burst abort

## Operation
- Reset: grant=0, wr_ready=0, lcd_valid=0, lcd_rs=0, lcd_data=0, timeout_err=0, state IDLE, RR pointer=0, counters 0.
- Output register holds one beat. Once lcd_valid=1, lcd_rs/lcd_data stay stable until lcd_valid&lcd_ready.
- IDLE (output register always empty here): if any req set, pick the first set bit scanning upward from the pointer, wrapping. Next edge: grant one-hot, latch addr slice, load the output register with {lcd_rs=0, lcd_data=8'h80|addr}, lcd_valid=1, char_cnt=0, stall_cnt=0, go STREAM.
- STREAM: wr_ready[g] = !lcd_valid | lcd_ready; all other wr_ready bits are 0. A beat transfers when wr_valid[g]&wr_ready[g], loading {rs=1, data=wr_data slice g} and incrementing char_cnt. A transfer with wr_last[g], or the MAX_LEN-th transfer, goes to DRAIN. Further characters are never accepted in that burst.
- Stall watchdog (STREAM only): stall_cnt increments on cycles with wr_valid[g]=0 and clears on any transfer. Downstream back-pressure with wr_valid[g]=1 does not count. When stall_cnt reaches TIMEOUT: timeout_err pulses 1 cycle, go DRAIN.
- DRAIN: wr_ready=0. When the output register is empty, or becomes empty on the current edge (lcd_valid&lcd_ready), go IDLE: grant=0, pointer=(g+1) mod N_REQ.
- req, addr, and wr_* of the owner are ignored mid-burst except as above. Dropping req does not end a burst. Inputs of non-owners are ignored.
- Reset mid-burst: all outputs drop asynchronously to their reset values. The in-flight beat is lost.

## Timing
- req sampled at edge t: grant and address command at lcd_valid by t+1. This is the earliest wr_ready (if lcd_ready=1 at t+1).
- Throughput: 1 beat/cycle with lcd_ready held high. Burst of L characters occupies L+1 output beats.
- Burst end: last beat accepted downstream at edge e gives grant=0 at e. New grant at e+1 at the earliest. Minimum one idle cycle between bursts.
- Simultaneous requests: the pointer rule guarantees each waiting requester a grant within N_REQ bursts.

## Test plan
- Single burst: req[1], addr=7'h40, "P1:" with wr_last on ':', lcd_ready=1 -> beats (0,0xC0),(1,'P'),(1,'1'),(1,':'). grant=3'b010 for 4 cycles, then 0.
- Contention: req=3'b111 held, 1-char bursts -> grant order 0,1,2,0. Pointer wraps. No requester is granted twice while another waits.
- Back-pressure: lcd_ready toggles 1/0 each cycle mid-burst -> lcd_data stable while lcd_ready=0. No character lost or duplicated. timeout_err stays 0.
- Timeout: TIMEOUT=8, owner sends 2 chars then drops wr_valid -> timeout_err pulse 8 cycles after the last transfer. Grant released after the pending beat drains. Next requester granted.
- Length cap: owner streams 20 chars with no wr_last -> exactly 16 data beats forwarded. wr_ready=0 from the 17th char on. Burst ends.
- Reset mid-burst: assert reset_n=0 with lcd_valid=1 -> lcd_valid, grant, wr_ready go 0 immediately. After release, the pointer restarts at requester 0.
